// File: rtl/ground_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : ground_scroller
//  Purpose  : Procedural, horizontally scrolling brick ground band. Brick and
//             tile geometry come from parameters. A frame-synchronous scroll
//             offset is kept and exported so other sprites can move with it.
//             Colour and opacity mask come out of a 2-stage pipeline.
//  Options  : GROUND_STAGGER_EN - offset odd brick courses by TILE_W/4
//             (staggered bond). When undefined, every course has the same
//             vertical joints.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module ground_scroller #(
    parameter int          TILE_W   = 16,
    parameter int          TILE_H   = 16,
    parameter int          COURSE_H = 4,
    parameter int          BASE_Y   = 448,
    parameter int          BAND_H   = 32,
    parameter int          H_ACTIVE = 640,
    parameter int          SPEED_W  = 4,
    parameter logic [7:0]  BRICK_R  = 8'h90,
    parameter logic [7:0]  BRICK_G  = 8'h40,
    parameter logic [7:0]  BRICK_B  = 8'h00,
    parameter logic [7:0]  MORTAR_R = 8'h00,
    parameter logic [7:0]  MORTAR_G = 8'h00,
    parameter logic [7:0]  MORTAR_B = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [10:0]                 ix,
    input  logic [10:0]                 iy,
    input  logic                        frame_tick,
    input  logic                        run,
    input  logic [SPEED_W-1:0]          speed,
    output logic [7:0]                  oR,
    output logic [7:0]                  oG,
    output logic [7:0]                  oB,
    output logic                        mask,
    output logic [$clog2(TILE_W)-1:0]   scroll
);

    // Geometry constants. All tile arithmetic is modulo a power of two, so
    // every division/modulo becomes a bit slice or a mask.
    localparam int               c_tw_bits    = $clog2(TILE_W);
    localparam int               c_th_bits    = $clog2(TILE_H);
    localparam logic [11:0]      c_band_top   = 12'(BASE_Y);
    localparam logic [11:0]      c_band_bot   = 12'(BASE_Y + BAND_H);
    localparam logic [11:0]      c_h_active   = 12'(H_ACTIVE);
    localparam logic [10:0]      c_base_y     = 11'(BASE_Y);
    // Low bits of ty selecting the row within a course; all ones = mortar row.
    localparam logic [c_th_bits-1:0] c_row_mask  = c_th_bits'(COURSE_H - 1);
    // Low bits of sx selecting the position within a half tile (one brick).
    localparam logic [c_tw_bits-1:0] c_half_mask = c_tw_bits'(TILE_W / 2 - 1);
`ifdef GROUND_STAGGER_EN
    // Bit of ty that equals course[0]; zero when a tile holds a single course.
    localparam logic [c_th_bits-1:0] c_course_bit = c_th_bits'(COURSE_H);
    localparam logic [c_tw_bits-1:0] c_quarter    = c_tw_bits'(TILE_W / 4);
`endif

    logic [c_tw_bits-1:0] r_scroll;
    logic [c_tw_bits-1:0] w_scroll_next;

    logic                 w_in_band;
    logic [c_tw_bits-1:0] w_tx;
    logic [10:0]          w_dy;
    logic [c_th_bits-1:0] w_ty;

    logic                 r_s1_in_band;
    logic [c_tw_bits-1:0] r_s1_tx;
    logic [c_th_bits-1:0] r_s1_ty;

    logic                 w_row_mortar;
    logic [c_tw_bits-1:0] w_stag;
    logic [c_tw_bits-1:0] w_sx;
    logic                 w_col_mortar;
    logic                 w_mortar;

    logic [7:0]           r_r;
    logic [7:0]           r_g;
    logic [7:0]           r_b;
    logic                 r_mask;

    // Advance by speed modulo TILE_W; the carry out of the top bit is dropped,
    // which is exactly the wrap from TILE_W-1 back through 0.
    always_comb begin
        w_scroll_next = r_scroll + c_tw_bits'(speed);
    end

    // Scroll register: updates only on a running frame tick, reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scroll <= '0;
        end else if (frame_tick && run) begin
            r_scroll <= w_scroll_next;
        end
    end

    assign scroll = r_scroll;

    // Stage-1 combinational: band membership and local tile coordinates.
    always_comb begin
        w_in_band = ({1'b0, iy} >= c_band_top) &&
                    ({1'b0, iy} <  c_band_bot) &&
                    ({1'b0, ix} <  c_h_active);
        w_tx      = ix[c_tw_bits-1:0] + r_scroll;
        w_dy      = iy - c_base_y;
        w_ty      = w_dy[c_th_bits-1:0];
    end

    // Stage-1 registers: capture band flag and tile coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_in_band <= 1'b0;
            r_s1_tx      <= '0;
            r_s1_ty      <= '0;
        end else begin
            r_s1_in_band <= w_in_band;
            r_s1_tx      <= w_tx;
            r_s1_ty      <= w_ty;
        end
    end

    // Stage-2 combinational: decide mortar versus brick for the tile pixel.
    always_comb begin
        w_row_mortar = ((r_s1_ty & c_row_mask) == c_row_mask);
`ifdef GROUND_STAGGER_EN
        w_stag       = ((r_s1_ty & c_course_bit) != '0) ? c_quarter : '0;
`else
        w_stag       = '0;
`endif
        w_sx         = r_s1_tx + w_stag;
        w_col_mortar = ((w_sx & c_half_mask) == c_half_mask);
        w_mortar     = w_row_mortar || w_col_mortar;
    end

    // Stage-2 registers: final colour and opacity; black/transparent outside.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r    <= 8'h00;
            r_g    <= 8'h00;
            r_b    <= 8'h00;
            r_mask <= 1'b0;
        end else if (!r_s1_in_band) begin
            r_r    <= 8'h00;
            r_g    <= 8'h00;
            r_b    <= 8'h00;
            r_mask <= 1'b0;
        end else if (w_mortar) begin
            r_r    <= MORTAR_R;
            r_g    <= MORTAR_G;
            r_b    <= MORTAR_B;
            r_mask <= 1'b1;
        end else begin
            r_r    <= BRICK_R;
            r_g    <= BRICK_G;
            r_b    <= BRICK_B;
            r_mask <= 1'b1;
        end
    end

    // Outputs are blanked while rst is asserted so the flush is already
    // visible in the reset cycle, before the cleared registers propagate.
    assign oR   = rst ? 8'h00 : r_r;
    assign oG   = rst ? 8'h00 : r_g;
    assign oB   = rst ? 8'h00 : r_b;
    assign mask = rst ? 1'b0  : r_mask;

endmodule
`default_nettype wire

// File: tb/tb_ground_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ground_scroller
//  Purpose  : Self-checking bench for ground_scroller (default parameters).
//             A pixel-level reference model checks every cycle; directed
//             vectors with literal expectations pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ground_scroller;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] ix;
    logic [10:0] iy;
    logic        frame_tick;
    logic        run;
    logic [3:0]  speed;
    logic [7:0]  oR;
    logic [7:0]  oG;
    logic [7:0]  oB;
    logic        mask;
    logic [3:0]  scroll;

    int checks = 0;
    int errors = 0;

    localparam logic [24:0] c_brick  = {24'h904000, 1'b1};
    localparam logic [24:0] c_mortar = {24'h000000, 1'b1};
    localparam logic [24:0] c_out    = 25'h0;

    ground_scroller dut (
        .clk        (clk),
        .rst        (rst),
        .ix         (ix),
        .iy         (iy),
        .frame_tick (frame_tick),
        .run        (run),
        .speed      (speed),
        .oR         (oR),
        .oG         (oG),
        .oB         (oB),
        .mask       (mask),
        .scroll     (scroll)
    );

    always #5 clk = ~clk;

    // Reference pixel: {R,G,B,mask} for screen pixel (x,y) at scroll s.
    function automatic logic [24:0] pix(int x, int y, int s);
        int tx;
        int ty;
        int sx;
        int stag;
        if (y < 448 || y >= 480 || x >= 640) return c_out;
        tx   = (x + s) % 16;
        ty   = (y - 448) % 16;
        if (ty % 4 == 3) return c_mortar;
        stag = 0;
`ifdef GROUND_STAGGER_EN
        if ((ty / 4) % 2 == 1) stag = 4;
`endif
        sx   = (tx + stag) % 16;
        return (sx % 8 == 7) ? c_mortar : c_brick;
    endfunction

    // Model state: pixel pending in each pipeline slot and the scroll value.
    logic [24:0] m_s1 = '0;
    logic [24:0] m_out = '0;
    int          m_scroll = 0;
    bit          m_started = 1'b0;

    always @(posedge clk) begin
        m_started = 1'b1;
        m_out     = rst ? c_out : m_s1;
        m_s1      = rst ? c_out : pix(int'(ix), int'(iy), m_scroll);
        if (rst)                      m_scroll = 0;
        else if (frame_tick && run)   m_scroll = (m_scroll + int'(speed)) % 16;
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        logic [24:0] exp_px;
        logic [3:0]  exp_sc;
        if (m_started) begin
            exp_px = rst ? c_out : m_out;
            exp_sc = 4'(m_scroll);
            checks++;
            if ({oR, oG, oB, mask} !== exp_px || scroll !== exp_sc) begin
                errors++;
                $display("FAIL model t=%0t got rgbm=%h scroll=%0d exp rgbm=%h scroll=%0d",
                         $time, {oR, oG, oB, mask}, scroll, exp_px, exp_sc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Present (x,y) for one cycle, then an off-band pixel; the output two
    // edges later must be the response to (x,y).
    task automatic pin(input string name, input int x, input int y, input logic [24:0] exp);
        ix = 11'(x);
        iy = 11'(y);
        @(posedge clk);
        #1;
        ix = 11'd700;
        iy = 11'd0;
        @(posedge clk);
        @(negedge clk);
        chk(name, 32'({oR, oG, oB, mask}), 32'(exp));
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [24:0] stag_exp;
        // Reset held 3 cycles with a running frame tick.
        rst = 1'b1; frame_tick = 1'b1; run = 1'b1; speed = 4'd5;
        ix = 11'd0; iy = 11'd448;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_mask", 32'(mask), 32'd0);
            chk("rst_rgb", 32'({oR, oG, oB}), 32'd0);
            chk("rst_scroll", 32'(scroll), 32'd0);
        end
        rst = 1'b0; frame_tick = 1'b0; speed = 4'd0;
        pin("reset_release", 0, 448, c_brick);

        // Static pattern at scroll 0.
        pin("static_brick", 0, 448, c_brick);
        pin("static_vjoint", 7, 448, c_mortar);
        pin("static_hjoint", 0, 451, c_mortar);

        // Scroll and wrap.
        speed = 4'd3; run = 1'b1;
        tick(3);
        chk("scroll_9", 32'(scroll), 32'd9);
        pin("scrolled_joint", 14, 448, c_mortar);
        tick(2);
        chk("scroll_15", 32'(scroll), 32'd15);
        tick(1);
        chk("scroll_wrap", 32'(scroll), 32'd2);
        run = 1'b0;
        tick(4);
        chk("scroll_hold", 32'(scroll), 32'd2);

        // Stagger, at scroll 0.
        rst_pulse();
        chk("scroll_cleared", 32'(scroll), 32'd0);
`ifdef GROUND_STAGGER_EN
        stag_exp = c_mortar;
`else
        stag_exp = c_brick;
`endif
        pin("stagger_course1", 3, 452, stag_exp);

        // Band edges.
        pin("edge_above", 0, 447, c_out);
        pin("edge_below", 0, 480, c_out);
        pin("edge_right", 640, 448, c_out);
        pin("edge_corner", 639, 479, c_mortar);

        // Reset mid-stream with scroll 6.
        run = 1'b1; speed = 4'd3;
        tick(2);
        chk("scroll_6", 32'(scroll), 32'd6);
        for (int i = 0; i < 20; i++) begin
            ix  = 11'(i * 3);
            iy  = 11'(449 + i % 10);
            rst = (i == 8);
            #1;
            if (i >= 8 && i <= 10) chk("mid_rst_zero", 32'({oR, oG, oB, mask}), 32'd0);
            if (i == 11)           chk("mid_rst_resume", 32'({oR, oG, oB, mask}), 32'(c_brick));
            @(posedge clk);
            #1;
            if (i == 8) chk("mid_rst_scroll", 32'(scroll), 32'd0);
        end
        rst = 1'b0;

        // Sweep across the band while scrolling at speed 7.
        speed = 4'd7;
        for (int i = 0; i < 80; i++) begin
            ix         = 11'((i * 5) % 660);
            iy         = 11'(444 + (i * 3) % 40);
            frame_tick = (i % 5 == 4);
            @(posedge clk);
            #1;
        end
        frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
